reg_scoreboard: RTL and testbench

Parametrised register scoreboard for the next-generation pipeline with variable-latency execution units (multi-cycle load, mul/div). Tracks outstanding writes per architectural destination register. Produces the decode-stage issue stall that replaces fixed load-use detection in the hazard unit. Sits between decode (issue side) and the writeback arbiter (completion side).

---
 rtl/reg_scoreboard_if.sv | 32 +++
 rtl/reg_scoreboard.sv | 101 ++++++++++
 tb/tb_reg_scoreboard.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/completion bus between decode, the writeback arbiter and the register scoreboard.
// master = decode/writeback side, slave = scoreboard.
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5
);
    logic              issue_valid;
    logic              issue_rd_write;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_rs1_use;
    logic [ADDR_W-1:0] issue_rs1;
    logic              issue_rs2_use;
    logic [ADDR_W-1:0] issue_rs2;
    logic              issue_stall;
    logic              issue_fire;
    logic              cmpl_valid;
    logic [ADDR_W-1:0] cmpl_rd;
    logic              flush;

    modport master (
        output issue_valid, issue_rd_write, issue_rd,
        output issue_rs1_use, issue_rs1, issue_rs2_use, issue_rs2,
        output cmpl_valid, cmpl_rd, flush,
        input  issue_stall, issue_fire
    );

    modport slave (
        input  issue_valid, issue_rd_write, issue_rd,
        input  issue_rs1_use, issue_rs1, issue_rs2_use, issue_rs2,
        input  cmpl_valid, cmpl_rd, flush,
        output issue_stall, issue_fire
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters driving the decode issue stall.
// Register 0 is hard-wired zero and can never become pending.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int MAX_OUT  = 4,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    reg_scoreboard_if.slave              sb,
    output logic [NUM_REGS-1:0]          pending_mask,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         busy,
    output logic                         err_underflow
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt      [NUM_REGS];
    logic [CNT_W-1:0] cnt_next [NUM_REGS];
    logic [CNT_W-1:0] c_rs1, c_rs2, c_rd, c_cmpl;
    logic             raw1, raw2, cap_full;
    logic             do_inc, do_dec, underflow;
    logic [OUT_W-1:0] outstanding_next;

    // Index by compare rather than array select so out-of-range addresses read as not pending.
    always_comb begin
        c_rs1  = '0;
        c_rs2  = '0;
        c_rd   = '0;
        c_cmpl = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sb.issue_rs1 == ADDR_W'(i)) c_rs1  = cnt[i];
            if (sb.issue_rs2 == ADDR_W'(i)) c_rs2  = cnt[i];
            if (sb.issue_rd  == ADDR_W'(i)) c_rd   = cnt[i];
            if (sb.cmpl_rd   == ADDR_W'(i)) c_cmpl = cnt[i];
        end
    end

    // The bypass only clears a hazard when the completing write is the last one outstanding.
    always_comb begin
        raw1 = sb.issue_rs1_use && (sb.issue_rs1 != '0) && (c_rs1 != '0);
        raw2 = sb.issue_rs2_use && (sb.issue_rs2 != '0) && (c_rs2 != '0);
        if (BYPASS != 0) begin
            if (sb.cmpl_valid && (sb.cmpl_rd == sb.issue_rs1) && (c_rs1 == CNT_W'(1)))
                raw1 = 1'b0;
            if (sb.cmpl_valid && (sb.cmpl_rd == sb.issue_rs2) && (c_rs2 == CNT_W'(1)))
                raw2 = 1'b0;
        end
        cap_full = sb.issue_rd_write && (sb.issue_rd != '0) &&
                   ((c_rd == CNT_MAX) || (outstanding == OUT_W'(MAX_OUT)));
    end

    assign sb.issue_stall = sb.issue_valid && (raw1 || raw2 || cap_full);
    assign sb.issue_fire  = sb.issue_valid && !sb.issue_stall && !sb.flush;

    assign do_inc    = sb.issue_fire && sb.issue_rd_write && (sb.issue_rd != '0);
    assign do_dec    = !sb.flush && sb.cmpl_valid && (sb.cmpl_rd != '0) && (c_cmpl != '0);
    assign underflow = !sb.flush && sb.cmpl_valid && (sb.cmpl_rd != '0) && (c_cmpl == '0);

    // Applying both deltas per register makes same-register issue+completion net to zero.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_next[i] = cnt[i];
            if (do_inc && (sb.issue_rd == ADDR_W'(i))) cnt_next[i] = cnt_next[i] + CNT_W'(1);
            if (do_dec && (sb.cmpl_rd == ADDR_W'(i)))  cnt_next[i] = cnt_next[i] - CNT_W'(1);
        end
    end

    always_comb begin
        outstanding_next = outstanding;
        case ({do_inc, do_dec})
            2'b10:   outstanding_next = outstanding + OUT_W'(1);
            2'b01:   outstanding_next = outstanding - OUT_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else if (sb.flush) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            outstanding <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_next[i];
            outstanding <= outstanding_next;
            if (underflow) err_underflow <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) pending_mask[i] = (cnt[i] != '0);
    end

    assign busy = (outstanding != '0);
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: scoreboard queue of expected registered state,
// inline checks of the combinational stall/fire per scenario.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv, rdw, u1, u2, cv, fl;
    logic [4:0] rd, rs1, rs2, crd;

    reg_scoreboard_if #(.ADDR_W(5)) sb_if ();
    reg_scoreboard_if #(.ADDR_W(5)) nb_if ();

    assign sb_if.issue_valid = iv;  assign nb_if.issue_valid = iv;
    assign sb_if.issue_rd_write = rdw; assign nb_if.issue_rd_write = rdw;
    assign sb_if.issue_rd = rd;     assign nb_if.issue_rd = rd;
    assign sb_if.issue_rs1_use = u1; assign nb_if.issue_rs1_use = u1;
    assign sb_if.issue_rs1 = rs1;   assign nb_if.issue_rs1 = rs1;
    assign sb_if.issue_rs2_use = u2; assign nb_if.issue_rs2_use = u2;
    assign sb_if.issue_rs2 = rs2;   assign nb_if.issue_rs2 = rs2;
    assign sb_if.cmpl_valid = cv;   assign nb_if.cmpl_valid = cv;
    assign sb_if.cmpl_rd = crd;     assign nb_if.cmpl_rd = crd;
    assign sb_if.flush = fl;        assign nb_if.flush = fl;

    logic [31:0] pending_mask, nb_mask;
    logic [2:0]  outstanding, nb_out;
    logic        busy, err_underflow, nb_busy, nb_err;

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .MAX_OUT(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .sb(sb_if), .pending_mask(pending_mask),
        .outstanding(outstanding), .busy(busy), .err_underflow(err_underflow));

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .MAX_OUT(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .sb(nb_if), .pending_mask(nb_mask),
        .outstanding(nb_out), .busy(nb_busy), .err_underflow(nb_err));

    typedef struct {
        logic [31:0] mask;
        logic [2:0]  out;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   mcnt[32];
    int   mout = 0;
    logic merr = 1'b0;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            tests++;
            if (pending_mask !== e.mask) begin
                fails++; $display("FAIL sb_pending_mask got %h want %h", pending_mask, e.mask);
            end
            tests++;
            if (outstanding !== e.out) begin
                fails++; $display("FAIL sb_outstanding got %0d want %0d", outstanding, e.out);
            end
            tests++;
            if (busy !== e.busy) begin
                fails++; $display("FAIL sb_busy got %b want %b", busy, e.busy);
            end
            tests++;
            if (err_underflow !== e.err) begin
                fails++; $display("FAIL sb_err_underflow got %b want %b", err_underflow, e.err);
            end
        end
    end

    task automatic drive(input logic a_iv, input logic a_rdw, input int a_rd,
                         input logic a_u1, input int a_rs1, input logic a_u2, input int a_rs2,
                         input logic a_cv, input int a_crd, input logic a_fl);
        iv = a_iv; rdw = a_rdw; rd = 5'(a_rd);
        u1 = a_u1; rs1 = 5'(a_rs1); u2 = a_u2; rs2 = 5'(a_rs2);
        cv = a_cv; crd = 5'(a_crd); fl = a_fl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Updates the reference state from the current inputs and the fire the test expects.
    task automatic tick(input logic exp_fire);
        exp_t e;
        logic inc, dec;
        if (fl) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            mout = 0;
        end else begin
            inc = exp_fire && rdw && (rd != 0);
            dec = cv && (crd != 0) && (mcnt[crd] != 0);
            if (cv && (crd != 0) && (mcnt[crd] == 0)) merr = 1'b1;
            if (inc) mcnt[rd] = mcnt[rd] + 1;
            if (dec) mcnt[crd] = mcnt[crd] - 1;
            mout = mout + int'(inc) - int'(dec);
        end
        foreach (mcnt[i]) e.mask[i] = (mcnt[i] != 0);
        e.out  = 3'(mout);
        e.busy = (mout != 0);
        e.err  = merr;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        iv = 1'b1; u1 = 1'b1; rs1 = 5'd5;
        #1;
        tests++;
        if ({pending_mask, outstanding, busy, err_underflow} !== '0) begin
            fails++; $display("FAIL reset_outputs got %h/%0d/%b/%b want 0/0/0/0",
                              pending_mask, outstanding, busy, err_underflow);
        end
        tests++;
        if (sb_if.issue_stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall got %b want 0", sb_if.issue_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick(0);
    endtask

    task automatic test_issue_raw();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_fire !== 1'b1) begin
            fails++; $display("FAIL issue_rd5_fire got %b want 1", sb_if.issue_fire);
        end
        tick(1);
        drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL raw_rs1_stall got %b want 1", sb_if.issue_stall);
        end
        tests++;
        if (sb_if.issue_fire !== 1'b0) begin
            fails++; $display("FAIL raw_rs1_fire got %b want 0", sb_if.issue_fire);
        end
        drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b0) begin
            fails++; $display("FAIL rs_zero_stall got %b want 0", sb_if.issue_stall);
        end
        idle();
        tick(0);
    endtask

    task automatic test_bypass();
        drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b0) begin
            fails++; $display("FAIL bypass_stall got %b want 0", sb_if.issue_stall);
        end
        tests++;
        if (sb_if.issue_fire !== 1'b1) begin
            fails++; $display("FAIL bypass_fire got %b want 1", sb_if.issue_fire);
        end
        tests++;
        if (nb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL nobypass_stall got %b want 1", nb_if.issue_stall);
        end
        tick(1);
        idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
            tests++;
            if (sb_if.issue_fire !== 1'b1) begin
                fails++; $display("FAIL sat_issue%0d_fire got %b want 1", k, sb_if.issue_fire);
            end
            tick(1);
        end
        drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL sat_full_stall got %b want 1", sb_if.issue_stall);
        end
        drive(1, 0, 0, 1, 7, 0, 0, 1, 7, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL bypass_cnt3_stall got %b want 1", sb_if.issue_stall);
        end
        tick(0);
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_fire !== 1'b1) begin
            fails++; $display("FAIL sat_after_cmpl_fire got %b want 1", sb_if.issue_fire);
        end
        tick(1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
            tick(0);
        end
        idle();
    endtask

    task automatic test_max_out();
        for (int r = 1; r <= 4; r++) begin
            drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
            tick(1);
        end
        drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL maxout_rd6_stall got %b want 1", sb_if.issue_stall);
        end
        drive(1, 1, 6, 0, 0, 0, 0, 1, 1, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b1) begin
            fails++; $display("FAIL maxout_cmpl_no_relief got %b want 1", sb_if.issue_stall);
        end
        drive(1, 0, 0, 1, 8, 1, 9, 0, 0, 0);
        tests++;
        if (sb_if.issue_fire !== 1'b1) begin
            fails++; $display("FAIL maxout_rsonly_fire got %b want 1", sb_if.issue_fire);
        end
        tick(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (sb_if.issue_stall !== 1'b0) begin
            fails++; $display("FAIL maxout_rd0_stall got %b want 0", sb_if.issue_stall);
        end
        tick(1);
        for (int r = 1; r <= 4; r++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
            tick(0);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        drive(1, 1, 9, 0, 0, 0, 0, 1, 9, 0);
        tests++;
        if (sb_if.issue_fire !== 1'b1) begin
            fails++; $display("FAIL same_rd_fire got %b want 1", sb_if.issue_fire);
        end
        tick(1);
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(1);
        drive(1, 1, 10, 0, 0, 0, 0, 1, 9, 0);
        tick(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
        tick(0);
        idle();
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
            tick(1);
        end
        drive(1, 1, 5, 0, 0, 0, 0, 1, 12, 1);
        tests++;
        if (sb_if.issue_fire !== 1'b0) begin
            fails++; $display("FAIL flush_fire got %b want 0", sb_if.issue_fire);
        end
        tick(0);
        idle();
    endtask

    task automatic test_underflow();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        tick(0);
        idle();
        tick(0);
        for (int r = 1; r <= 3; r++) begin
            drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
            tick(1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(0);
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        drive(1, 1, 11, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        idle();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({pending_mask, outstanding, busy, err_underflow} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs got %h/%0d/%b/%b want 0/0/0/0",
                              pending_mask, outstanding, busy, err_underflow);
        end
        foreach (mcnt[i]) mcnt[i] = 0;
        mout = 0;
        merr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tick(0);
    endtask

    initial begin
        foreach (mcnt[i]) mcnt[i] = 0;
        test_reset();
        test_issue_raw();
        test_bypass();
        test_saturation();
        test_max_out();
        test_same_cycle();
        test_flush();
        test_underflow();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
